// File: rtl/regfile_param_if.sv
// Register-file bus: read/write ports plus ready/wr_err status toward the control unit.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              ready;
  logic              wr_err;

  modport master (
    output RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData,
    input  ReadData1, ReadData2, ready, wr_err
  );

  modport slave (
    input  RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData,
    output ReadData1, ReadData2, ready, wr_err
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file, reg 0 hardwired to zero, array cleared by a post-reset sweep.
// Optional write-through forwarding to the read ports: define REGFILE_WR_BYPASS_EN.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic            clk,
  input logic            reset,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ZERO  = '0;
  localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic              wr_err_q, wr_err_d;

  // Entry 0 has no storage; reads of index 0 are forced to zero below.
  logic [DATA_W-1:0] mem_q [1:DEPTH-1];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_req;
  logic [DATA_W-1:0] rd1, rd2;

  function automatic logic [DATA_W-1:0] read_stored(
    input state_t            st,
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored
  );
    if (st == ST_READY && idx != IDX_ZERO) return stored;
    return '0;
  endfunction

  assign wr_req = bus.RegWrite && (bus.WriteReg != IDX_ZERO);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ready_d  = ready_q;
    wr_err_d = 1'b0;
    if (state_q == ST_INIT) begin
      // The last sweep edge is still not ready, so a write there is flagged too.
      wr_err_d = wr_req;
      if (ptr_q == PTR_LAST) begin
        state_d = ST_READY;
        ready_d = 1'b1;
      end else begin
        ptr_d = ptr_q + PTR_FIRST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      ptr_q    <= PTR_FIRST;
      ready_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ready_q  <= ready_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        mem_we = (ptr_q != IDX_ZERO);
      end else if (wr_req) begin
        mem_we    = 1'b1;
        mem_waddr = bus.WriteReg;
        mem_wdata = bus.WriteData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rd1 = read_stored(state_q, bus.ReadReg1, mem_q[bus.ReadReg1]);
    rd2 = read_stored(state_q, bus.ReadReg2, mem_q[bus.ReadReg2]);
`ifdef REGFILE_WR_BYPASS_EN
    // wr_req already excludes index 0, so reg 0 is never forwarded.
    if (state_q == ST_READY && wr_req && bus.WriteReg == bus.ReadReg1) rd1 = bus.WriteData;
    if (state_q == ST_READY && wr_req && bus.WriteReg == bus.ReadReg2) rd2 = bus.WriteData;
`endif
  end

  assign bus.ReadData1 = rd1;
  assign bus.ReadData2 = rd2;
  assign bus.ready     = ready_q;
  assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: reset sweep, read/write, reg 0, INIT writes, mid-sweep reset, bypass.
module tb_regfile_param;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      it = sb_q.pop_front();
      chk(it.tag, obs, it.exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_ready(input int start, output int edges);
    edges = start;
    while (edges < 100) begin
      tick();
      edges++;
      if (bus.ready) break;
    end
  endtask

  logic [31:0] bypass_exp;
  int edges;

  initial begin
`ifdef REGFILE_WR_BYPASS_EN
    bypass_exp = 32'hA5A5A5A5;
`else
    bypass_exp = 32'h0;
`endif
    reset         = 1'b1;
    bus.RegWrite  = 1'b0;
    bus.ReadReg1  = 5'd4;
    bus.ReadReg2  = 5'd0;
    bus.WriteReg  = 5'd0;
    bus.WriteData = 32'h0;

    // Reset state
    tick();
    tick();
    sb_push("rst_ready", 32'd0);      sb_pop(32'(bus.ready));
    sb_push("rst_wr_err", 32'd0);     sb_pop(32'(bus.wr_err));
    sb_push("rst_rd1", 32'd0);        sb_pop(bus.ReadData1);
    reset = 1'b0;

    // Sweep: ready first seen after edge 31
    run_to_ready(0, edges);
    sb_push("sweep_edges", 32'd31);   sb_pop(32'(edges));

    for (int i = 1; i < 32; i++) begin
      bus.ReadReg1 = 5'(i);
      bus.ReadReg2 = 5'(32 - i);
      @(negedge clk);
      sb_push($sformatf("clr_rd1_%0d", i), 32'd0); sb_pop(bus.ReadData1);
      sb_push($sformatf("clr_rd2_%0d", 32 - i), 32'd0); sb_pop(bus.ReadData2);
    end
    tick();

    // Bypass on reg 5 before the edge
    bus.RegWrite  = 1'b1;
    bus.WriteReg  = 5'd5;
    bus.WriteData = 32'hA5A5A5A5;
    bus.ReadReg1  = 5'd5;
    bus.ReadReg2  = 5'd0;
    @(negedge clk);
    sb_push("byp_rd1", bypass_exp);   sb_pop(bus.ReadData1);
    sb_push("byp_rd2_r0", 32'd0);     sb_pop(bus.ReadData2);
    tick();
    bus.RegWrite = 1'b0;
    @(negedge clk);
    sb_push("byp_after", 32'hA5A5A5A5); sb_pop(bus.ReadData1);
    tick();

    // Basic write/read on reg 7
    bus.RegWrite  = 1'b1;
    bus.WriteReg  = 5'd7;
    bus.WriteData = 32'hDEADBEEF;
    bus.ReadReg1  = 5'd8;
    bus.ReadReg2  = 5'd8;
    @(negedge clk);
    sb_push("r8_pre", 32'd0);         sb_pop(bus.ReadData1);
    tick();
    bus.RegWrite = 1'b0;
    sb_push("wr7_no_err", 32'd0);     sb_pop(32'(bus.wr_err));
    bus.ReadReg1 = 5'd7;
    bus.ReadReg2 = 5'd7;
    @(negedge clk);
    sb_push("r7_port1", 32'hDEADBEEF); sb_pop(bus.ReadData1);
    sb_push("r7_port2", 32'hDEADBEEF); sb_pop(bus.ReadData2);
    bus.ReadReg1 = 5'd8;
    #2;
    sb_push("r8_post", 32'd0);        sb_pop(bus.ReadData1);
    tick();

    // Writes to reg 0 are dropped silently
    bus.RegWrite  = 1'b1;
    bus.WriteReg  = 5'd0;
    bus.WriteData = 32'h12345678;
    bus.ReadReg1  = 5'd0;
    @(negedge clk);
    sb_push("r0_pre", 32'd0);         sb_pop(bus.ReadData1);
    tick();
    bus.RegWrite = 1'b0;
    sb_push("r0_no_err", 32'd0);      sb_pop(32'(bus.wr_err));
    @(negedge clk);
    sb_push("r0_post", 32'd0);        sb_pop(bus.ReadData1);
    tick();

    // Write during INIT at the 4th edge after release
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    bus.RegWrite  = 1'b1;
    bus.WriteReg  = 5'd3;
    bus.WriteData = 32'd5;
    bus.ReadReg1  = 5'd7;
    @(negedge clk);
    sb_push("init_rd_gated", 32'd0);  sb_pop(bus.ReadData1);
    tick();
    bus.RegWrite = 1'b0;
    sb_push("init_wr_err_hi", 32'd1); sb_pop(32'(bus.wr_err));
    sb_push("init_not_ready", 32'd0); sb_pop(32'(bus.ready));
    tick();
    sb_push("init_wr_err_lo", 32'd0); sb_pop(32'(bus.wr_err));
    run_to_ready(5, edges);
    sb_push("init_sweep_edges", 32'd31); sb_pop(32'(edges));
    bus.ReadReg1 = 5'd3;
    bus.ReadReg2 = 5'd7;
    @(negedge clk);
    sb_push("r3_dropped", 32'd0);     sb_pop(bus.ReadData1);
    sb_push("r7_swept", 32'd0);       sb_pop(bus.ReadData2);
    tick();

    // Mid-sweep reset at ptr=10
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (9) tick();
    sb_push("mid_not_ready", 32'd0);  sb_pop(32'(bus.ready));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_to_ready(0, edges);
    sb_push("mid_restart_edges", 32'd31); sb_pop(32'(edges));

    // Write on the final INIT edge is dropped and flagged
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (30) tick();
    sb_push("last_not_ready", 32'd0); sb_pop(32'(bus.ready));
    bus.RegWrite  = 1'b1;
    bus.WriteReg  = 5'd9;
    bus.WriteData = 32'hCAFEF00D;
    tick();
    bus.RegWrite = 1'b0;
    sb_push("last_ready", 32'd1);     sb_pop(32'(bus.ready));
    sb_push("last_wr_err", 32'd1);    sb_pop(32'(bus.wr_err));
    bus.ReadReg1 = 5'd9;
    @(negedge clk);
    sb_push("r9_dropped", 32'd0);     sb_pop(bus.ReadData1);
    tick();
    sb_push("last_wr_err_lo", 32'd0); sb_pop(32'(bus.wr_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
